// File: rtl/ifetch_pkg.sv
// Shared constants, queue entry type and predecode helper for the instruction fetch stage.
// Optional predecode storage is enabled with IFETCH_PREDECODE_EN.
package ifetch_pkg;
  localparam int INST_W    = 32;
  localparam int ADDR_W    = 64;
  localparam int DW_ADDR_W = 61;

  localparam logic [5:0] OP_BC = 6'd16;
  localparam logic [5:0] OP_SC = 6'd17;
  localparam logic [5:0] OP_B  = 6'd18;
  localparam logic [5:0] OP_XL = 6'd19;

  // Vectors are held LSB-0 internally: MSB-0 bit k is LSB-0 bit (W-1-k).
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
`ifdef IFETCH_PREDECODE_EN
    logic              is_branch;
`endif
  } fetch_entry_t;

`ifdef IFETCH_PREDECODE_EN
  function automatic logic is_branch_op(input logic [5:0] opcode);
    return opcode inside {OP_BC, OP_SC, OP_B, OP_XL};
  endfunction
`endif
endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: two-entry write port, one-entry read port, flush.
// Head data reads as zero while the queue is empty.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [1:0]         wr_n,
  input  fetch_entry_t       wr_data0,
  input  fetch_entry_t       wr_data1,
  input  logic               rd_en,
  output fetch_entry_t       rd_data,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   free
);
  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage is not reset; the zero-gated head covers the reset output values.
  always_ff @(posedge clk) begin
    if (!flush && wr_n != 2'd0) mem_q[wr_ptr_q] <= wr_data0;
    if (!flush && wr_n == 2'd2) mem_q[wr_ptr_q + PTR_W'(1)] <= wr_data1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_n);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
      count_d  = count_q + CNT_W'(wr_n) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;
  assign free    = CNT_W'(DEPTH) - count_q;
endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch/prefetch stage: doubleword read, big-endian word select, queue, redirect.
// Define IFETCH_PREDECODE_EN to add the inst_is_branch output.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic [DW_ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0]    mem_data,
  output logic                 inst_valid,
  output logic [INST_W-1:0]    inst,
  output logic [ADDR_W-1:0]    inst_pc,
`ifdef IFETCH_PREDECODE_EN
  output logic                 inst_is_branch,
`endif
  input  logic                 inst_ready
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count, free;
  logic [1:0]        wr_n;
  fetch_entry_t      wr_e0, wr_e1, head;
  logic              fire;

  function automatic fetch_entry_t mk_entry(input logic [INST_W-1:0] w,
                                            input logic [ADDR_W-1:0] pc);
    fetch_entry_t e;
    e.inst = w;
    e.pc   = pc;
`ifdef IFETCH_PREDECODE_EN
    e.is_branch = is_branch_op(w[31:26]);
`endif
    return e;
  endfunction

  // MSB-0 mem_data[0:31] is the upper half; fetch_pc[61] is LSB-0 bit 2.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_n       = 2'd0;
    wr_e0      = '0;
    wr_e1      = '0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~64'h3;
    end else if (free == '0) begin
      fetch_pc_d = fetch_pc_q;
    end else if (!fetch_pc_q[2]) begin
      wr_e0 = mk_entry(mem_data[63:32], fetch_pc_q);
      if (free >= CNT_W'(2)) begin
        wr_n       = 2'd2;
        wr_e1      = mk_entry(mem_data[31:0], fetch_pc_q + 64'd4);
        fetch_pc_d = fetch_pc_q + 64'd8;
      end else begin
        wr_n       = 2'd1;
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
    end else begin
      wr_n       = 2'd1;
      wr_e0      = mk_entry(mem_data[31:0], fetch_pc_q);
      fetch_pc_d = fetch_pc_q + 64'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_pc_q <= RESET_PC;
    else        fetch_pc_q <= fetch_pc_d;
  end

  assign inst_valid = (count != '0) && !redirect_valid;
  assign fire       = inst_valid && inst_ready;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .wr_n     (wr_n),
    .wr_data0 (wr_e0),
    .wr_data1 (wr_e1),
    .rd_en    (fire),
    .rd_data  (head),
    .count    (count),
    .free     (free)
  );

  assign mem_addr = fetch_pc_q[ADDR_W-1:3];
  assign inst     = head.inst;
  assign inst_pc  = head.pc;
`ifdef IFETCH_PREDECODE_EN
  assign inst_is_branch = head.is_branch;
`endif
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch against a word-level queue model.
module tb_ifetch_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk, rst_n, redirect_valid, inst_ready, inst_valid;
  logic [63:0] redirect_pc, mem_data, inst_pc;
  logic [60:0] mem_addr;
  logic [31:0] inst;
`ifdef IFETCH_PREDECODE_EN
  logic        inst_is_branch;
`endif

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
`ifdef IFETCH_PREDECODE_EN
    .inst_is_branch (inst_is_branch),
`endif
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mpc;
  logic        exp_valid, exp_br;
  logic [31:0] exp_inst;
  logic [63:0] exp_pc;
  logic [60:0] exp_addr;
  int          tests, fails;
  logic [31:0] salt;

  // Word-addressed program image.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h38000041;
      64'h4:   return 32'h44000002;
      64'h20:  return 32'h48000010;
      64'h24:  return 32'h7C632214;
      default: return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ salt;
    endcase
  endfunction

  always_comb mem_data = {word_at({mem_addr, 3'b000}), word_at({mem_addr, 3'b100})};

  task automatic apply(input bit rdy, input bit redir, input logic [63:0] rpc);
    @(negedge clk);
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    exp_valid = (mq.size() != 0) && !redir;
    exp_inst  = (mq.size() != 0) ? mq[0].inst : 32'h0;
    exp_pc    = (mq.size() != 0) ? mq[0].pc : 64'h0;
    exp_addr  = mpc[63:3];
    exp_br    = exp_inst[31:26] inside {6'd16, 6'd17, 6'd18, 6'd19};
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic advance();
    int   free, taken;
    ent_t e;
    if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[63:2], 2'b00};
      return;
    end
    free = DEPTH - mq.size();
    if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
    taken = 0;
    while (taken < free) begin
      e.inst = word_at(mpc);
      e.pc   = mpc;
      mq.push_back(e);
      mpc   = mpc + 64'd4;
      taken++;
      if (mpc[2] == 1'b0) break;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    mpc = RESET_PC;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    #12;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h want 0", inst); end
    tests++; if (inst_pc !== 64'h0) begin fails++; $display("FAIL reset_pc got %h want 0", inst_pc); end
    tests++; if (mem_addr !== RESET_PC[63:3]) begin fails++; $display("FAIL reset_addr got %h want %h", mem_addr, RESET_PC[63:3]); end
    do_reset();
  endtask

  task automatic test_basic();
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, 1'b0, 64'h0);
      tests++; if (inst_valid !== exp_valid) begin fails++; $display("FAIL basic_valid c%0d got %0b want %0b", k, inst_valid, exp_valid); end
      tests++; if (exp_valid && (inst !== exp_inst || inst_pc !== exp_pc)) begin fails++; $display("FAIL basic_head c%0d got %h@%h want %h@%h", k, inst, inst_pc, exp_inst, exp_pc); end
      tests++; if (mem_addr !== exp_addr) begin fails++; $display("FAIL basic_addr c%0d got %h want %h", k, mem_addr, exp_addr); end
      if (k == 1) begin
        tests++; if (inst !== 32'h38000041 || inst_pc !== 64'h0) begin fails++; $display("FAIL basic_first got %h@%h want 38000041@0", inst, inst_pc); end
      end
      if (k == 2) begin
        tests++; if (inst !== 32'h44000002 || inst_pc !== 64'h4) begin fails++; $display("FAIL basic_second got %h@%h want 44000002@4", inst, inst_pc); end
      end
      if (k < 3) begin
        tests++; if (mem_addr !== 61'(k)) begin fails++; $display("FAIL basic_step c%0d got %h want %0d", k, mem_addr, k); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 64'h0);
      tests++; if (mem_addr !== ((k < 2) ? 61'(k) : 61'd2)) begin fails++; $display("FAIL stall_addr c%0d got %h", k, mem_addr); end
      tests++; if (inst_valid !== exp_valid) begin fails++; $display("FAIL stall_valid c%0d got %0b want %0b", k, inst_valid, exp_valid); end
      advance();
    end
    for (int j = 0; j < 6; j++) begin
      apply(1'b1, 1'b0, 64'h0);
      tests++; if (inst_valid !== 1'b1 || inst_pc !== 64'(4 * j)) begin fails++; $display("FAIL drain_pc c%0d got %0b %h want 1 %h", j, inst_valid, inst_pc, 4 * j); end
      tests++; if (inst !== exp_inst || mem_addr !== exp_addr) begin fails++; $display("FAIL drain_head c%0d got %h/%h want %h/%h", j, inst, mem_addr, exp_inst, exp_addr); end
      advance();
    end
  endtask

  task automatic test_redirect();
    apply(1'b1, 1'b1, 64'h14);
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redir_valid got %0b want 0", inst_valid); end
    advance();
    apply(1'b1, 1'b0, 64'h0);
    tests++; if (mem_addr !== 61'd2 || inst_valid !== 1'b0) begin fails++; $display("FAIL redir_addr got %h %0b want 2 0", mem_addr, inst_valid); end
    advance();
    apply(1'b1, 1'b0, 64'h0);
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 64'h14 || inst !== word_at(64'h14) || mem_addr !== 61'd3) begin fails++; $display("FAIL redir_first got %0b %h@%h a%h", inst_valid, inst, inst_pc, mem_addr); end
    advance();
    apply(1'b1, 1'b0, 64'h0);
    tests++; if (inst_pc !== 64'h18 || inst !== word_at(64'h18)) begin fails++; $display("FAIL redir_next got %h@%h want pc 18", inst, inst_pc); end
    advance();
    for (int k = 0; k < 4; k++) begin apply(1'b0, 1'b0, 64'h0); advance(); end
    apply(1'b1, 1'b1, 64'h22);
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL full_redir_valid got %0b want 0", inst_valid); end
    advance();
    apply(1'b1, 1'b0, 64'h0);
    tests++; if (inst_valid !== 1'b0 || mem_addr !== 61'd4) begin fails++; $display("FAIL full_redir_flush got %0b a%h want 0 a4", inst_valid, mem_addr); end
    advance();
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 1'b0, 64'h0);
      tests++; if (inst_valid !== 1'b1 || inst_pc !== 64'h20 + 64'(4 * k) || inst !== exp_inst) begin fails++; $display("FAIL full_redir_head c%0d got %h@%h want %h@%h", k, inst, inst_pc, exp_inst, exp_pc); end
`ifdef IFETCH_PREDECODE_EN
      tests++; if (inst_is_branch !== (k == 0)) begin fails++; $display("FAIL predecode c%0d got %0b want %0b", k, inst_is_branch, k == 0); end
`endif
      advance();
    end
    apply(1'b1, 1'b1, 64'h100); advance();
    apply(1'b1, 1'b1, 64'h40);  advance();
    apply(1'b1, 1'b0, 64'h0);
    tests++; if (mem_addr !== 61'd8) begin fails++; $display("FAIL b2b_redir got %h want 8", mem_addr); end
    advance();
  endtask

  task automatic test_wrap();
    apply(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    advance();
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b0, 64'h0);
      tests++; if (inst_valid !== exp_valid || mem_addr !== exp_addr) begin fails++; $display("FAIL wrap_ctl c%0d got %0b a%h want %0b a%h", k, inst_valid, mem_addr, exp_valid, exp_addr); end
      tests++; if (exp_valid && (inst !== exp_inst || inst_pc !== exp_pc)) begin fails++; $display("FAIL wrap_head c%0d got %h@%h want %h@%h", k, inst, inst_pc, exp_inst, exp_pc); end
      if (k == 1) begin
        tests++; if (inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_top got %h", inst_pc); end
      end
      if (k == 2) begin
        tests++; if (inst_pc !== 64'h0) begin fails++; $display("FAIL wrap_zero got %h want 0", inst_pc); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    bit          rdy, redir;
    logic [63:0] rpc;
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 64'h0 || mem_addr !== RESET_PC[63:3]) begin fails++; $display("FAIL async_reset got %0b %h@%h a%h", inst_valid, inst, inst_pc, mem_addr); end
        do_reset();
      end
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = {$urandom(), $urandom()};
      apply(rdy, redir, rpc);
      tests++; if (inst_valid !== exp_valid || mem_addr !== exp_addr) begin fails++; $display("FAIL rand_ctl c%0d got %0b a%h want %0b a%h", k, inst_valid, mem_addr, exp_valid, exp_addr); end
      tests++; if (exp_valid && (inst !== exp_inst || inst_pc !== exp_pc)) begin fails++; $display("FAIL rand_head c%0d got %h@%h want %h@%h", k, inst, inst_pc, exp_inst, exp_pc); end
`ifdef IFETCH_PREDECODE_EN
      tests++; if (exp_valid && inst_is_branch !== exp_br) begin fails++; $display("FAIL rand_br c%0d got %0b want %0b", k, inst_is_branch, exp_br); end
`endif
      advance();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    salt  = $urandom();
    mpc   = RESET_PC;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction fetch stage upstream of the single-cycle PPC execute core.
- Drives the core's doubleword instruction read port, selects big-endian 32-bit words, and buffers them in a small prefetch queue.
- Presents one instruction per cycle to decode with a valid/ready handshake.
- Execute redirects the stream via a redirect request on taken branches, bclr and sc.

Parameters:
- DEPTH, 4, queue capacity in instruction words; power of 2, ≥2.
- RESET_PC, 64'h0, fetch address after reset; bits [62:63] must be 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- redirect_valid  input  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  input  [0:63]  new fetch address; bits [62:63] ignored and treated as 0.
- mem_addr  output  [0:60]  doubleword read address to the combinational memory read port.
- mem_data  input  [0:63]  doubleword returned in the same cycle; [0:31] is the word at byte offset 0, [32:63] at offset 4.
- inst_valid  output  1  queue head is valid.
- inst  output  [0:31]  instruction at queue head.
- inst_pc  output  [0:63]  byte address of inst.
- inst_ready  input  1  decode accepts the head this cycle.

Behaviour:
- All vectors use MSB-0 numbering.

Reset (rst_n low, asynchronous):
- count=0, rd/wr pointers=0, fetch_pc=RESET_PC.
- inst_valid=0, inst=0, inst_pc=0, mem_addr=RESET_PC[0:60].

Memory port:
- mem_addr = fetch_pc[0:60] combinationally, every cycle. There is no request strobe.
- Read data is consumed in the same cycle.

Enqueue rule:
- free = DEPTH − count, from registered count. A same-cycle dequeue does not add space.
- fetch_pc[61]=0 and free≥2: enqueue mem_data[0:31] then mem_data[32:63] with PCs fetch_pc and fetch_pc+4; fetch_pc += 8.
- fetch_pc[61]=0 and free=1: enqueue mem_data[0:31] only; fetch_pc += 4.
- fetch_pc[61]=1 and free≥1: enqueue mem_data[32:63]; fetch_pc += 4.
- free=0: no enqueue; fetch_pc holds.
- fetch_pc wraps modulo 2^64.

Dequeue:
- inst_valid = (count≠0) & ~redirect_valid.
- Fire = inst_valid & inst_ready. On fire, rd_ptr advances by 1 at the next edge.
- inst and inst_pc always show the head entry. They are don't-care when inst_valid=0.

Count and pointers:
- count_next = count + enq_n − fire.
- Pointers wrap modulo DEPTH.
- Simultaneous enqueue and dequeue at full or empty follows the free rule above. The queue never overflows or underflows.

Redirect (highest priority):
- The same-cycle enqueue and dequeue are suppressed.
- At the next edge: count=0, pointers=0, fetch_pc={redirect_pc[0:61],2'b00}.
- The first instruction from the new target can appear, valid, in the cycle after the redirect edge.
- Back-to-back redirects: the last one wins.
- Reset asserted mid-operation discards all state immediately.

Latency:
- One cycle from fetch address to inst_valid; no bypass from mem_data to inst.
- Steady-state throughput: one instruction per cycle when inst_ready is held high.

Optional Feature:
- Macro: IFETCH_PREDECODE_EN.
- When defined:
  - Each queue entry stores an extra bit is_branch = (opcode==16 | opcode==18 | opcode==19 | opcode==17), computed at enqueue from inst[0:5].
  - The bit is exposed on an added output port inst_is_branch (1 bit, reset 0) that tracks the head entry.
- When undefined:
  - The port and its storage are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Package ifetch_pkg:
  - Constants INST_W=32, ADDR_W=64, DW_ADDR_W=61.
  - Opcode constants OP_BC=16, OP_SC=17, OP_B=18, OP_XL=19.
  - Typedef fetch_entry_t {inst[0:31], pc[0:63], is_branch under the macro}.
- Sub-module fetch_queue:
  - Circular buffer of fetch_entry_t with a 2-entry write port (wr_n 0..2), a 1-entry read port, flush, and count/free outputs.
  - ifetch_prefetch holds fetch_pc, word selection, enqueue decision and redirect priority.

Test Plan:
- Reset, then release with mem returning 64'h38000041_44000002 at addr 0 and inst_ready=1 → cycle 1: inst=32'h38000041, pc=0; cycle 2: inst=32'h44000002, pc=4; mem_addr steps 0,1,2.
- inst_ready=0 with DEPTH=4 → count reaches 4 after two cycles; mem_addr holds 2; raise inst_ready → words drain in order at PCs 0,4,8,C with no loss or duplication.
- Misaligned redirect: redirect_pc=64'h14 → next edge flushes; mem_addr=2; first inst is mem_data[32:63] with pc=0x14; next pc=0x18 from mem_addr=3.
- Redirect with queue full and inst_ready=1 → inst_valid=0 that cycle, no fire, count=0 next cycle; new PCs only.
- Reset pulse mid-stream → outputs return to reset values asynchronously; fetch resumes at RESET_PC.
- With IFETCH_PREDECODE_EN: inst 32'h48000010 (b) → inst_is_branch=1; 32'h7C632214 (add) → 0.
